// File: rtl/branch_hazard_ctrl.sv
// Branch hazard / redirect controller for the ID-stage branch comparator.
// Optional statistics counters are built when BRANCH_STAT_EN is defined.
module branch_hazard_ctrl #(
    parameter int unsigned MAX_STALL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Op_ID,
    input  logic [4:0]  rs_ID,
    input  logic [4:0]  rt_ID,
    input  logic        EX_ctrl_RegWr,
    input  logic        EX_ctrl_MemRd,
    input  logic [4:0]  WriteDst_EX,
    input  logic        MEM_ctrl_RegWr,
    input  logic        MEM_ctrl_MemRd,
    input  logic [4:0]  WriteDst_MEM,
    input  logic        brSignal,
    output logic        PCWr,
    output logic        IFIDWr,
    output logic        IDEX_bubble,
    output logic        IFID_flush,
    output logic        br_redirect,
    output logic [1:0]  stall_cnt,
    output logic        stall_err
`ifdef BRANCH_STAT_EN
    ,
    output logic [15:0] br_cnt,
    output logic [15:0] br_taken_cnt,
    output logic [15:0] br_stall_cnt
`endif
);

    localparam logic [5:0] INSTR_BEQ_OP = 6'b000100;
    localparam logic [5:0] INSTR_BNE_OP = 6'b000101;

    typedef enum logic {RUN, STALL} state_t;

    state_t state;
    logic   is_branch;
    logic   ex_match;
    logic   mem_match;
    logic   h1;
    logic   h2;
    logic   haz;
    logic   taken;

    // $0 is hardwired, so a write to it can never feed the comparator.
    always_comb begin
        is_branch = (Op_ID == INSTR_BEQ_OP) || (Op_ID == INSTR_BNE_OP);
        ex_match  = (WriteDst_EX != 5'd0) &&
                    ((WriteDst_EX == rs_ID) || (WriteDst_EX == rt_ID));
        mem_match = (WriteDst_MEM != 5'd0) &&
                    ((WriteDst_MEM == rs_ID) || (WriteDst_MEM == rt_ID));
        h1        = EX_ctrl_MemRd && EX_ctrl_RegWr && ex_match;
        h2        = MEM_ctrl_RegWr && !MEM_ctrl_MemRd && mem_match;
        haz       = is_branch && (h1 || h2);
        taken     = !haz && is_branch && brSignal;
    end

    // NOTE: every output gets a value on every path so no latch is inferred.
    always_comb begin
        if (rst) begin
            PCWr        = 1'b0;
            IFIDWr      = 1'b0;
            IDEX_bubble = 1'b1;
            IFID_flush  = 1'b1;
            br_redirect = 1'b0;
        end else begin
            PCWr        = !haz;
            IFIDWr      = !haz;
            IDEX_bubble = haz;
            br_redirect = taken;
            IFID_flush  = taken;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= 2'd0;
            stall_err <= 1'b0;
        end else begin
            case (state)
                RUN:     state <= haz ? STALL : RUN;
                STALL:   state <= haz ? STALL : RUN;
                default: state <= RUN;
            endcase
            if (haz) begin
                if (stall_cnt != 2'd3)
                    stall_cnt <= stall_cnt + 2'd1;
                if (stall_cnt == 2'(MAX_STALL))
                    stall_err <= 1'b1;
            end else if (state == STALL) begin
                stall_cnt <= 2'd0;
            end
        end
    end

`ifdef BRANCH_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            br_cnt       <= 16'd0;
            br_taken_cnt <= 16'd0;
            br_stall_cnt <= 16'd0;
        end else begin
            if (is_branch && !haz && br_cnt != 16'hFFFF)
                br_cnt <= br_cnt + 16'd1;
            if (taken && br_taken_cnt != 16'hFFFF)
                br_taken_cnt <= br_taken_cnt + 16'd1;
            if (haz && br_stall_cnt != 16'hFFFF)
                br_stall_cnt <= br_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed bench for branch_hazard_ctrl: a combinational vector table plus
// hand-written multi-cycle sequences (stall, saturation, reset, statistics).
module tb_branch_hazard_ctrl;

    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] BNE = 6'b000101;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  Op_ID;
    logic [4:0]  rs_ID, rt_ID;
    logic        EX_ctrl_RegWr, EX_ctrl_MemRd;
    logic [4:0]  WriteDst_EX;
    logic        MEM_ctrl_RegWr, MEM_ctrl_MemRd;
    logic [4:0]  WriteDst_MEM;
    logic        brSignal;
    logic        PCWr, IFIDWr, IDEX_bubble, IFID_flush, br_redirect;
    logic [1:0]  stall_cnt;
    logic        stall_err;
`ifdef BRANCH_STAT_EN
    logic [15:0] br_cnt, br_taken_cnt, br_stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_hazard_ctrl #(.MAX_STALL(2)) dut (
        .clk(clk), .rst(rst), .Op_ID(Op_ID), .rs_ID(rs_ID), .rt_ID(rt_ID),
        .EX_ctrl_RegWr(EX_ctrl_RegWr), .EX_ctrl_MemRd(EX_ctrl_MemRd),
        .WriteDst_EX(WriteDst_EX), .MEM_ctrl_RegWr(MEM_ctrl_RegWr),
        .MEM_ctrl_MemRd(MEM_ctrl_MemRd), .WriteDst_MEM(WriteDst_MEM),
        .brSignal(brSignal), .PCWr(PCWr), .IFIDWr(IFIDWr),
        .IDEX_bubble(IDEX_bubble), .IFID_flush(IFID_flush),
        .br_redirect(br_redirect), .stall_cnt(stall_cnt), .stall_err(stall_err)
`ifdef BRANCH_STAT_EN
        , .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt), .br_stall_cnt(br_stall_cnt)
`endif
    );

    // exp = {PCWr, IFIDWr, IDEX_bubble, IFID_flush, br_redirect}
    typedef struct {
        string      name;
        logic [5:0] op;
        logic [4:0] rs, rt;
        logic       ex_wr, ex_rd;
        logic [4:0] ex_dst;
        logic       mem_wr, mem_rd;
        logic [4:0] mem_dst;
        logic       br;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[12];

    function automatic logic [4:0] outs();
        return {PCWr, IFIDWr, IDEX_bubble, IFID_flush, br_redirect};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ex_wr, input logic ex_rd, input logic [4:0] ex_dst,
                         input logic mem_wr, input logic mem_rd, input logic [4:0] mem_dst,
                         input logic br);
        Op_ID = op; rs_ID = rs; rt_ID = rt;
        EX_ctrl_RegWr = ex_wr; EX_ctrl_MemRd = ex_rd; WriteDst_EX = ex_dst;
        MEM_ctrl_RegWr = mem_wr; MEM_ctrl_MemRd = mem_rd; WriteDst_MEM = mem_dst;
        brSignal = br;
    endtask

    task automatic idle();
        drive(6'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{"non_branch_h1",  6'd0, 5'd2, 5'd3, 1, 1, 5'd2, 0, 0, 5'd0, 1, 5'b11000};
        vecs[1]  = '{"h1_rs",          BEQ,  5'd2, 5'd3, 1, 1, 5'd2, 0, 0, 5'd0, 1, 5'b00100};
        vecs[2]  = '{"h1_rt",          BEQ,  5'd2, 5'd3, 1, 1, 5'd3, 0, 0, 5'd0, 1, 5'b00100};
        vecs[3]  = '{"h2_mem_alu",     BNE,  5'd5, 5'd4, 0, 0, 5'd0, 1, 0, 5'd4, 1, 5'b00100};
        vecs[4]  = '{"ex_alu_fwd",     BNE,  5'd5, 5'd4, 1, 0, 5'd4, 0, 0, 5'd0, 1, 5'b11011};
        vecs[5]  = '{"mem_load_fwd",   BEQ,  5'd5, 5'd4, 0, 0, 5'd0, 1, 1, 5'd4, 0, 5'b11000};
        vecs[6]  = '{"r0_ex_load",     BEQ,  5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 5'd0, 1, 5'b11011};
        vecs[7]  = '{"r0_mem_alu",     BEQ,  5'd0, 5'd0, 0, 0, 5'd0, 1, 0, 5'd0, 1, 5'b11011};
        vecs[8]  = '{"ex_rd_no_wr",    BEQ,  5'd2, 5'd3, 0, 1, 5'd2, 0, 0, 5'd0, 0, 5'b11000};
        vecs[9]  = '{"bne_taken_free", BNE,  5'd7, 5'd8, 0, 0, 5'd0, 0, 0, 5'd0, 1, 5'b11011};
        vecs[10] = '{"other_op",       6'b000110, 5'd2, 5'd3, 1, 1, 5'd2, 0, 0, 5'd0, 1, 5'b11000};
        vecs[11] = '{"h1_and_h2",      BEQ,  5'd2, 5'd3, 1, 1, 5'd2, 1, 0, 5'd3, 1, 5'b00100};

        idle();
        rst = 1'b1;
        #12;
        check("reset_outs", 16'(outs()), 16'b00110);
        check("reset_stall_cnt", 16'(stall_cnt), 16'd0);
        check("reset_stall_err", 16'(stall_err), 16'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].ex_wr, vecs[i].ex_rd,
                  vecs[i].ex_dst, vecs[i].mem_wr, vecs[i].mem_rd, vecs[i].mem_dst, vecs[i].br);
            #1;
            check(vecs[i].name, 16'(outs()), 16'(vecs[i].exp));
        end

        // lw $2 in EX, beq $2,$3 taken: one stall, then redirect.
        idle();
        do_reset();
        drive(BEQ, 5'd2, 5'd3, 1, 1, 5'd2, 0, 0, 5'd0, 1);
        #1;
        check("lw_beq_stall_outs", 16'(outs()), 16'b00100);
        @(negedge clk);
        check("lw_beq_stall_cnt1", 16'(stall_cnt), 16'd1);
        drive(BEQ, 5'd2, 5'd3, 0, 0, 5'd0, 1, 1, 5'd2, 1);
        #1;
        check("lw_beq_redirect_outs", 16'(outs()), 16'b11011);
        @(negedge clk);
        check("lw_beq_stall_cnt0", 16'(stall_cnt), 16'd0);

        // add $4 in MEM, bne $5,$4: one stall then release.
        drive(BNE, 5'd5, 5'd4, 0, 0, 5'd0, 1, 0, 5'd4, 0);
        #1;
        check("add_mem_stall_outs", 16'(outs()), 16'b00100);
        @(negedge clk);
        check("add_mem_stall_cnt1", 16'(stall_cnt), 16'd1);
        drive(BNE, 5'd5, 5'd4, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        @(negedge clk);
        check("add_mem_stall_cnt0", 16'(stall_cnt), 16'd0);

        // H1 held three cycles: saturation path and sticky error.
        drive(BEQ, 5'd2, 5'd3, 1, 1, 5'd3, 0, 0, 5'd0, 0);
        @(negedge clk);
        check("hold_cnt1", 16'(stall_cnt), 16'd1);
        check("hold_err1", 16'(stall_err), 16'd0);
        @(negedge clk);
        check("hold_cnt2", 16'(stall_cnt), 16'd2);
        check("hold_err2", 16'(stall_err), 16'd0);
        @(negedge clk);
        check("hold_cnt3", 16'(stall_cnt), 16'd3);
        check("hold_err3", 16'(stall_err), 16'd1);
        @(negedge clk);
        check("hold_cnt_sat", 16'(stall_cnt), 16'd3);
        idle();
        @(negedge clk);
        check("drop_cnt0", 16'(stall_cnt), 16'd0);
        check("drop_err_sticky", 16'(stall_err), 16'd1);

        // Reset asserted mid-stall.
        drive(BEQ, 5'd2, 5'd3, 1, 1, 5'd2, 0, 0, 5'd0, 1);
        @(negedge clk);
        check("pre_rst_cnt1", 16'(stall_cnt), 16'd1);
        rst = 1'b1;
        #1;
        check("mid_stall_rst_outs", 16'(outs()), 16'b00110);
        check("mid_stall_rst_cnt", 16'(stall_cnt), 16'd0);
        idle();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_cnt", 16'(stall_cnt), 16'd0);
        check("post_rst_err", 16'(stall_err), 16'd0);
        check("post_rst_outs", 16'(outs()), 16'b11000);

`ifdef BRANCH_STAT_EN
        // 5 branches, 3 taken, 2 stall cycles.
        drive(BEQ, 5'd2, 5'd3, 1, 1, 5'd2, 0, 0, 5'd0, 1);
        @(negedge clk);
        drive(BEQ, 5'd2, 5'd3, 0, 0, 5'd0, 0, 0, 5'd0, 1);
        @(negedge clk);
        drive(BNE, 5'd5, 5'd4, 0, 0, 5'd0, 1, 0, 5'd4, 0);
        @(negedge clk);
        drive(BNE, 5'd5, 5'd4, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        drive(BEQ, 5'd1, 5'd1, 0, 0, 5'd0, 0, 0, 5'd0, 1);
        @(negedge clk);
        drive(BNE, 5'd1, 5'd6, 0, 0, 5'd0, 0, 0, 5'd0, 1);
        @(negedge clk);
        drive(BEQ, 5'd1, 5'd6, 0, 0, 5'd0, 0, 0, 5'd0, 0);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("br_cnt", br_cnt, 16'd5);
        check("br_taken_cnt", br_taken_cnt, 16'd3);
        check("br_stall_cnt", br_stall_cnt, 16'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
